// File: rtl/fft_mem_core.sv
// rtl/fft_mem_core.sv - memory-based radix-2 DIT FFT/IFFT core with streaming I/O
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inv                   inverse select, latched on the accepted sop_in beat
//   valid_in, sop_in      input beat valid / first sample of a frame
//   ready_in              core accepts input beats (LOAD only)
//   x_re, x_im            signed input sample
//   tw_addr               twiddle index k to an external combinational ROM
//   tw_re, tw_im          W^k from the ROM, same cycle as tw_addr
//   valid_out, ready_out  output beat handshake
//   sop_out, eop_out      bin 0 / bin N-1 markers
//   y_re, y_im            signed output bin
//   frame_err             one-cycle pulse when sop_in restarts a partial load
module fft_mem_core #(
  parameter int LOG2N = 8,
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inv,
  input  logic                 valid_in,
  input  logic                 sop_in,
  output logic                 ready_in,
  input  logic signed [DW-1:0] x_re,
  input  logic signed [DW-1:0] x_im,
  output logic [LOG2N-2:0]     tw_addr,
  input  logic signed [TW-1:0] tw_re,
  input  logic signed [TW-1:0] tw_im,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 frame_err
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = $clog2(LOG2N + 1);
  // Product of a DW sample and a sign-extended (TW+1) twiddle, plus one bit for the sum
  localparam int PW = DW + TW + 2;
  localparam logic signed [PW-1:0] SMAX = (PW'(1) << (DW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;
  localparam logic [LOG2N-1:0] LAST  = LOG2N'(N - 1);
  localparam logic [LOG2N-2:0] BLAST = '1;
  localparam logic [SW-1:0]    SLAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {S_LOAD, S_COMP, S_OUT} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic signed [PW-1:0] scl(input logic signed [PW-1:0] v);
    return (SCALE != 0) ? (v >>> 1) : v;
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SMAX) return SMAX[DW-1:0];
    else if (v < SMIN) return SMIN[DW-1:0];
    else return v[DW-1:0];
  endfunction

  state_t              r_state, w_state_nx;
  logic [LOG2N-1:0]    r_cnt, w_cnt_nx;
  logic [SW-1:0]       r_stage, w_stage_nx;
  logic [LOG2N-2:0]    r_bfly, w_bfly_nx;
  logic                r_inv, w_inv_nx;
  logic                r_ferr, w_ferr_nx;
  logic                w_acc, w_load_we, w_bfly_we;
  logic [LOG2N-1:0]    w_load_addr;

  logic signed [DW-1:0] r_mem_re [N];
  logic signed [DW-1:0] r_mem_im [N];

  // Butterfly index mapping: b splits into group (b>>s) and offset j within the group
  logic [LOG2N-1:0] w_b, w_half, w_j, w_p, w_q;
  assign w_b    = {1'b0, r_bfly};
  assign w_half = LOG2N'(1) << r_stage;
  assign w_j    = w_b & (w_half - LOG2N'(1));
  assign w_p    = ((w_b >> r_stage) << (r_stage + SW'(1))) + w_j;
  assign w_q    = w_p + w_half;
  assign tw_addr = (r_state == S_COMP) ? (w_j[LOG2N-2:0] << (SLAST - r_stage)) : '0;

  logic signed [PW-1:0] w_xpr, w_xpi, w_ar, w_ai, w_wr, w_wi, w_pr, w_pi, w_tr, w_ti;
  logic signed [DW-1:0] w_yp_re, w_yp_im, w_yq_re, w_yq_im;
  assign w_xpr = PW'(r_mem_re[w_p]);
  assign w_xpi = PW'(r_mem_im[w_p]);
  assign w_ar  = PW'(r_mem_re[w_q]);
  assign w_ai  = PW'(r_mem_im[w_q]);
  assign w_wr  = PW'(tw_re);
  // Inverse uses the conjugate twiddle; extended first so negating the most negative code is exact
  assign w_wi  = r_inv ? -PW'(tw_im) : PW'(tw_im);
  assign w_pr  = w_ar * w_wr - w_ai * w_wi;
  assign w_pi  = w_ar * w_wi + w_ai * w_wr;
  assign w_tr  = w_pr >>> (TW - 3);
  assign w_ti  = w_pi >>> (TW - 3);
  assign w_yp_re = sat(scl(w_xpr + w_tr));
  assign w_yp_im = sat(scl(w_xpi + w_ti));
  assign w_yq_re = sat(scl(w_xpr - w_tr));
  assign w_yq_im = sat(scl(w_xpi - w_ti));

  assign ready_in    = (r_state == S_LOAD);
  assign valid_out   = (r_state == S_OUT);
  assign sop_out     = valid_out && (r_cnt == '0);
  assign eop_out     = valid_out && (r_cnt == LAST);
  assign y_re        = valid_out ? r_mem_re[r_cnt] : '0;
  assign y_im        = valid_out ? r_mem_im[r_cnt] : '0;
  assign frame_err   = r_ferr;
  assign w_acc       = valid_in && ready_in;
  assign w_load_addr = sop_in ? '0 : bitrev(r_cnt);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_stage_nx = r_stage;
    w_bfly_nx  = r_bfly;
    w_inv_nx   = r_inv;
    w_ferr_nx  = 1'b0;
    w_load_we  = 1'b0;
    w_bfly_we  = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_acc) begin
          if (sop_in) begin
            // A nonzero count means a frame was in progress: restart it
            w_load_we = 1'b1;
            w_inv_nx  = inv;
            w_cnt_nx  = LOG2N'(1);
            w_ferr_nx = (r_cnt != '0);
          end else if (r_cnt != '0) begin
            w_load_we = 1'b1;
            if (r_cnt == LAST) begin
              w_state_nx = S_COMP;
              w_cnt_nx   = '0;
              w_stage_nx = '0;
              w_bfly_nx  = '0;
            end else begin
              w_cnt_nx = r_cnt + LOG2N'(1);
            end
          end
        end
      end
      S_COMP: begin
        w_bfly_we = 1'b1;
        if (r_bfly == BLAST) begin
          w_bfly_nx = '0;
          if (r_stage == SLAST) begin
            w_state_nx = S_OUT;
            w_stage_nx = '0;
          end else begin
            w_stage_nx = r_stage + SW'(1);
          end
        end else begin
          w_bfly_nx = r_bfly + (LOG2N-1)'(1);
        end
      end
      S_OUT: begin
        if (ready_out) begin
          if (r_cnt == LAST) begin
            w_state_nx = S_LOAD;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + LOG2N'(1);
          end
        end
      end
      default: w_state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_stage <= '0;
      r_bfly  <= '0;
      r_inv   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_stage <= w_stage_nx;
      r_bfly  <= w_bfly_nx;
      r_inv   <= w_inv_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  // Buffer has no reset; p and q never collide within one butterfly
  always_ff @(posedge clk) begin
    if (!rst && w_load_we) begin
      r_mem_re[w_load_addr] <= x_re;
      r_mem_im[w_load_addr] <= x_im;
    end
    if (!rst && w_bfly_we) begin
      r_mem_re[w_p] <= w_yp_re;
      r_mem_im[w_p] <= w_yp_im;
      r_mem_re[w_q] <= w_yq_re;
      r_mem_im[w_q] <= w_yq_im;
    end
  end

endmodule

// File: tb/tb_fft_mem_core.sv
// tb/tb_fft_mem_core.sv - self-checking bench for fft_mem_core (SCALE=1 and SCALE=0 instances)
module tb_fft_mem_core;
  localparam int LOG2N = 8;
  localparam int N = 256;
  localparam int H = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, inv = 1'b0, valid_in = 1'b0, sop_in = 1'b0, ready_out = 1'b1;
  logic signed [15:0] x_re = '0, x_im = '0;
  logic [1:0] ready_in_d, valid_out_d, sop_out_d, eop_out_d, frame_err_d;
  logic [1:0][15:0] y_re_d, y_im_d, tw_re_d, tw_im_d;
  logic [1:0][6:0] tw_addr_d;

  int rom_re[H], rom_im[H];
  int in_re[N], in_im[N];
  int exp_re[2][N], exp_im[2][N], cap_re[2][N], cap_im[2][N];
  int kidx[2], xfers[2], ferr_hi[2];
  int n_assert = 0, n_fail = 0;
  bit bp_en = 0;
  int bp_ph = 0;

  assign tw_re_d[0] = 16'(rom_re[tw_addr_d[0]]);
  assign tw_im_d[0] = 16'(rom_im[tw_addr_d[0]]);
  assign tw_re_d[1] = 16'(rom_re[tw_addr_d[1]]);
  assign tw_im_d[1] = 16'(rom_im[tw_addr_d[1]]);

  fft_mem_core #(.LOG2N(8), .DW(16), .TW(16), .SCALE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .inv(inv), .valid_in(valid_in), .sop_in(sop_in),
    .ready_in(ready_in_d[0]), .x_re(x_re), .x_im(x_im), .tw_addr(tw_addr_d[0]),
    .tw_re(tw_re_d[0]), .tw_im(tw_im_d[0]), .valid_out(valid_out_d[0]),
    .ready_out(ready_out), .sop_out(sop_out_d[0]), .eop_out(eop_out_d[0]),
    .y_re(y_re_d[0]), .y_im(y_im_d[0]), .frame_err(frame_err_d[0]));

  fft_mem_core #(.LOG2N(8), .DW(16), .TW(16), .SCALE(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .inv(inv), .valid_in(valid_in), .sop_in(sop_in),
    .ready_in(ready_in_d[1]), .x_re(x_re), .x_im(x_im), .tw_addr(tw_addr_d[1]),
    .tw_re(tw_re_d[1]), .tw_im(tw_im_d[1]), .valid_out(valid_out_d[1]),
    .ready_out(ready_out), .sop_out(sop_out_d[1]), .eop_out(eop_out_d[1]),
    .y_re(y_re_d[1]), .y_im(y_im_d[1]), .frame_err(frame_err_d[1]));

  task automatic chk(input string name, input longint act, input longint req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint req, input longint tol);
    n_assert++;
    if (act > req + tol || act < req - tol) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d +/- %0d", name, act, req, tol);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int rev8(input int n);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (n & (1 << i)) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  function automatic longint fdiv(input longint a, input longint m);
    return (a >= 0) ? a / m : -((-a + m - 1) / m);
  endfunction

  function automatic longint fin(input longint v, input bit sc);
    longint t = sc ? fdiv(v, 2) : v;
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
  endfunction

  // Reference transform: bit-reversed load, then every stage's butterflies in plain integer math
  task automatic model(input int d, input bit iv);
    longint br[N], bi[N];
    longint wr, wi, pr, pi, tr, ti, a0, a1, a2, a3;
    int j, p, q, k;
    bit sc = (d == 0);
    for (int n = 0; n < N; n++) begin
      br[rev8(n)] = in_re[n];
      bi[rev8(n)] = in_im[n];
    end
    for (int s = 0; s < LOG2N; s++) begin
      for (int b = 0; b < H; b++) begin
        j = b % (1 << s);
        p = (b / (1 << s)) * (1 << (s + 1)) + j;
        q = p + (1 << s);
        k = j * (1 << (LOG2N - 1 - s));
        wr = rom_re[k];
        wi = iv ? -rom_im[k] : rom_im[k];
        pr = br[q] * wr - bi[q] * wi;
        pi = br[q] * wi + bi[q] * wr;
        tr = fdiv(pr, 8192);
        ti = fdiv(pi, 8192);
        a0 = fin(br[p] + tr, sc);
        a1 = fin(bi[p] + ti, sc);
        a2 = fin(br[p] - tr, sc);
        a3 = fin(bi[p] - ti, sc);
        br[p] = a0; bi[p] = a1; br[q] = a2; bi[q] = a3;
      end
    end
    for (int n = 0; n < N; n++) begin
      exp_re[d][n] = int'(br[n]);
      exp_im[d][n] = int'(bi[n]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      ready_out = (bp_ph == 0 || bp_ph == 3);
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      ready_out = 1'b1;
    end
  end

  // Output checker: every cycle with valid_out, both instances against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (frame_err_d[d]) ferr_hi[d]++;
      if (valid_out_d[d]) begin
        if (kidx[d] >= N) begin
          chk($sformatf("d%0d_extra_beat", d), kidx[d], N - 1);
        end else begin
          chk($sformatf("d%0d_k%0d_y_re", d, kidx[d]), $signed(y_re_d[d]), exp_re[d][kidx[d]]);
          chk($sformatf("d%0d_k%0d_y_im", d, kidx[d]), $signed(y_im_d[d]), exp_im[d][kidx[d]]);
          chk($sformatf("d%0d_k%0d_sop", d, kidx[d]), sop_out_d[d], kidx[d] == 0);
          chk($sformatf("d%0d_k%0d_eop", d, kidx[d]), eop_out_d[d], kidx[d] == N - 1);
          chk($sformatf("d%0d_k%0d_ready_in", d, kidx[d]), ready_in_d[d], 0);
          if (ready_out) begin
            cap_re[d][kidx[d]] = $signed(y_re_d[d]);
            cap_im[d][kidx[d]] = $signed(y_im_d[d]);
            kidx[d]++;
            xfers[d]++;
          end
        end
      end
    end
  end

  task automatic beat(input bit v, input bit s, input int re, input int im);
    valid_in = v; sop_in = s; x_re = 16'(re); x_im = 16'(im);
    @(posedge clk); #1;
  endtask

  task automatic idle_reset_check(input string tag);
    chk({tag, "_ready_in"}, ready_in_d, 2'b11);
    chk({tag, "_valid_out"}, valid_out_d, 0);
    chk({tag, "_sop_eop"}, {sop_out_d, eop_out_d}, 0);
    chk({tag, "_frame_err"}, frame_err_d, 0);
    chk({tag, "_y"}, {y_re_d, y_im_d}, 0);
    chk({tag, "_tw_addr"}, tw_addr_d, 0);
  endtask

  task automatic run_frame(input string tag, input bit iv, input int junk, input int restart,
                           input int gap, input int exp_ferr, input bit bp, input int abort);
    int lat, rdy_bad, t;
    model(0, iv);
    model(1, iv);
    for (int d = 0; d < 2; d++) begin kidx[d] = 0; xfers[d] = 0; ferr_hi[d] = 0; end
    bp_en = bp;
    for (int i = 0; i < junk; i++) beat(1, 0, 9000, -9000);
    if (restart > 0) begin
      inv = ~iv;
      for (int n = 0; n < restart; n++) beat(1, n == 0, 7000, 7000);
    end
    for (int n = 0; n < N; n++) begin
      if (gap > 0 && n % gap == gap - 1) beat(0, 1, 1234, 1234);
      inv = (n == 0) ? iv : ~iv;
      beat(1, n == 0, in_re[n], in_im[n]);
    end
    valid_in = 0; sop_in = 0; inv = 0;
    if (abort > 0) begin
      repeat (abort) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      idle_reset_check({tag, "_after_reset"});
      @(posedge clk); #1;
      return;
    end
    lat = 0; rdy_bad = 0;
    while (lat < 1200) begin
      @(negedge clk);
      lat++;
      if (valid_out_d[0]) break;
      if (ready_in_d != 0) rdy_bad++;
    end
    chk({tag, "_latency"}, lat, 1025);
    chk({tag, "_valid_both"}, valid_out_d, 2'b11);
    chk({tag, "_ready_in_comp"}, rdy_bad, 0);
    t = 0;
    while ((xfers[0] < N || xfers[1] < N) && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    chk({tag, "_xfers_s1"}, xfers[0], N);
    chk({tag, "_xfers_s0"}, xfers[1], N);
    @(negedge clk); #1;
    chk({tag, "_post_valid"}, valid_out_d, 0);
    chk({tag, "_post_ready_in"}, ready_in_d, 2'b11);
    chk({tag, "_ferr_s1"}, ferr_hi[0], exp_ferr);
    chk({tag, "_ferr_s0"}, ferr_hi[1], exp_ferr);
    bp_en = 0;
    @(posedge clk); #1;
  endtask

  task automatic set_frame(input int k0, input int v0, input int vall);
    for (int n = 0; n < N; n++) begin
      in_re[n] = (n == k0) ? v0 : vall;
      in_im[n] = 0;
    end
  endtask

  task automatic chk_zero_except0(input string tag, input int d);
    int nz = 0;
    for (int k = 1; k < N; k++) if (cap_re[d][k] != 0 || cap_im[d][k] != 0) nz++;
    chk({tag, "_nonzero_bins"}, nz, 0);
  endtask

  task automatic chk_all3(input string tag);
    int bad = 0;
    for (int k = 0; k < N; k++) if (cap_re[0][k] != 3 || cap_im[0][k] != 0) bad++;
    chk({tag, "_bins_not_3"}, bad, 0);
    chk({tag, "_bin0_re"}, cap_re[0][0], 3);
    chk({tag, "_bin255_re"}, cap_re[0][255], 3);
  endtask

  initial begin
    for (int k = 0; k < H; k++) begin
      rom_re[k] = rnd(8192.0 * $cos(2.0 * 3.14159265358979 * k / N));
      rom_im[k] = rnd(-8192.0 * $sin(2.0 * 3.14159265358979 * k / N));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_reset_check("reset");
    @(posedge clk); #1 rst = 0;

    set_frame(0, 1000, 0);
    run_frame("impulse", 0, 0, 0, 0, 0, 0, 0);
    chk_all3("impulse");

    set_frame(0, 100, 100);
    run_frame("dc100", 0, 0, 0, 0, 0, 0, 0);
    chk("dc100_y0_re", cap_re[1][0], 25600);
    chk("dc100_y0_im", cap_im[1][0], 0);
    chk_zero_except0("dc100", 1);

    set_frame(0, 200, 200);
    run_frame("dc200", 0, 0, 0, 0, 0, 0, 0);
    chk("dc200_y0_sat", cap_re[1][0], 32767);
    chk_zero_except0("dc200", 1);

    set_frame(1, 1000, 0);
    run_frame("tone_fwd", 0, 0, 0, 0, 0, 0, 0);
    chk_tol("tone_fwd_y64_re", cap_re[1][64], 0, 2);
    chk_tol("tone_fwd_y64_im", cap_im[1][64], -1000, 2);
    chk_tol("tone_fwd_y0_re", cap_re[1][0], 1000, 2);
    chk_tol("tone_fwd_y0_im", cap_im[1][0], 0, 2);

    run_frame("tone_inv", 1, 0, 0, 0, 0, 0, 0);
    chk_tol("tone_inv_y64_re", cap_re[1][64], 0, 2);
    chk_tol("tone_inv_y64_im", cap_im[1][64], 1000, 2);

    run_frame("backpressure", 0, 0, 0, 0, 0, 1, 0);
    chk_tol("bp_y64_im", cap_im[1][64], -1000, 2);

    run_frame("framing", 0, 5, 100, 7, 1, 0, 0);
    chk_tol("framing_y64_im", cap_im[1][64], -1000, 2);
    chk_tol("framing_y0_re", cap_re[1][0], 1000, 2);

    set_frame(0, 1000, 0);
    run_frame("abort", 0, 0, 0, 0, 0, 0, 500);
    run_frame("impulse2", 0, 0, 0, 0, 0, 0, 0);
    chk_all3("impulse2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
